// File: rtl/hdc_prune_arbiter.sv
// ---------------------------------------------------------------------------
// hdc_prune_arbiter
//
// Shares the random-projection pruning datapath between the HDC encoder
// (bundling during training) and the associative search (query vs. class HVs).
// A granted pass walks the segment-select counter `ctr` through
// 0..SEQ_CYCLE_COUNT-1, one segment per enabled cycle, then pulses the
// owner's done output for one cycle.
//
// Parameters
//   SEQ_CYCLE_COUNT : segments per pruning pass (2..256)
//   CTR_W           : width of ctr, $clog2(SEQ_CYCLE_COUNT)
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   en              : global enable; low blocks new grants and stalls a pass
//   enc_req         : encoder request (level)
//   srch_req        : search request (level)
//   enc_gnt         : encoder owns the datapath
//   srch_gnt        : search owns the datapath
//   enc_done        : one-cycle pulse, encoder pass complete
//   srch_done       : one-cycle pulse, search pass complete
//   pruning_hv      : datapath segment valid this cycle
//   ctr             : segment select for the pruning MUX
//   busy            : arbiter not idle
//
// Handshake: a requester raises its req and holds it as a level. The grant
// rises the cycle after the request is sampled in idle and stays high for the
// whole pass (including stall cycles). Completion is signalled by a one-cycle
// done pulse with the grant already low; the requester must drop req by the
// cycle after that pulse or it re-arbitrates. Dropping req while granted
// aborts the pass without a done pulse.
// ---------------------------------------------------------------------------
module hdc_prune_arbiter #(
  parameter int SEQ_CYCLE_COUNT = 4,
  parameter int CTR_W           = $clog2(SEQ_CYCLE_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             enc_req,
  input  logic             srch_req,
  output logic             enc_gnt,
  output logic             srch_gnt,
  output logic             enc_done,
  output logic             srch_done,
  output logic             pruning_hv,
  output logic [CTR_W-1:0] ctr,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRUNE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(SEQ_CYCLE_COUNT - 1);

  // owner / last_owner encoding: 0 = encoder, 1 = search
  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;

  logic             owner_req;
  logic             in_prune;

  assign owner_req = owner_q ? srch_req : enc_req;
  assign in_prune  = (state_q == S_PRUNE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;   // encoder wins the first tie after reset
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;

    case (state_q)
      S_IDLE: begin
        ctr_d = '0;
        if (en && (enc_req || srch_req)) begin
          state_d = S_PRUNE;
          // Tie: serve whoever was not served last (round-robin).
          if (enc_req && srch_req) owner_d = ~last_owner_q;
          else                     owner_d = srch_req;
        end
      end

      S_PRUNE: begin
        // Abort outranks both stall and completion.
        if (!owner_req) begin
          state_d = S_IDLE;
          ctr_d   = '0;
        end else if (en) begin
          if (ctr_q == CTR_LAST) begin
            state_d = S_DONE;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + CTR_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d      = S_IDLE;
        ctr_d        = '0;
        last_owner_d = owner_q;
      end

      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  // Grants, done pulses and ctr decode registered state only. The segment
  // valid additionally gates on en (stall) and on the owner still requesting
  // (no segment is consumed in the abort cycle).
  assign enc_gnt    = in_prune & ~owner_q;
  assign srch_gnt   = in_prune &  owner_q;
  assign enc_done   = (state_q == S_DONE) & ~owner_q;
  assign srch_done  = (state_q == S_DONE) &  owner_q;
  assign pruning_hv = in_prune & en & owner_req;
  assign ctr        = ctr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/hdc_prune_arbiter.md
# hdc_prune_arbiter

Arbitrates the shared random-projection pruning datapath between two requesters: the encoder (bundling features during training) and the associative search (comparing a query HV against class HVs). On grant it sequences the pruning pass, stepping the segment-select counter `ctr` once per cycle for `SEQ_CYCLE_COUNT` cycles, then returns a one-cycle done pulse to the owner. It sits between the encoder/search control FSMs and the pruning MUX/datapath, replacing per-requester pruning control.

## Interface
- `SEQ_CYCLE_COUNT`, 4: segments per pruning pass; legal range 2–256.
- `CTR_W`, `$clog2(SEQ_CYCLE_COUNT)`: width of `ctr`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable; low = no new grant, stall the active pass.
- `enc_req` in 1: encoder request; level, held until `enc_done` or withdrawn.
- `srch_req` in 1: search request; level, same rules.
- `enc_gnt` out 1: encoder owns datapath (high in S_PRUNE with owner=0).
- `srch_gnt` out 1: search owns datapath (high in S_PRUNE with owner=1).
- `enc_done` out 1: one-cycle pulse, encoder pass complete.
- `srch_done` out 1: one-cycle pulse, search pass complete.
- `pruning_hv` out 1: datapath segment valid this cycle.
- `ctr` out CTR_W: segment select for pruning MUX.
- `busy` out 1: state ≠ S_IDLE.

## Operation
- States: S_IDLE, S_PRUNE, S_DONE. Registers: `state`, `ctr`, `owner`, `last_owner`.
- S_IDLE: if `en` and any request → S_PRUNE, latch `owner`, `ctr`←0. Else stay.
- Arbitration (S_IDLE only): single request wins; both requesting → the one ≠ `last_owner` (round-robin). Reset `last_owner`=search, so encoder wins first tie.
- S_PRUNE, `en`=1, owner's req=1: `pruning_hv`=1; if `ctr`==SEQ_CYCLE_COUNT-1 → S_DONE, else `ctr`←`ctr`+1.
- S_PRUNE, `en`=0: stall; `ctr` holds, `pruning_hv`=0, grant stays high.
- S_PRUNE, owner's req drops: abort → S_IDLE, `ctr`←0, no done pulse, `last_owner` unchanged. Abort has priority over stall and completion.
- S_DONE: owner's done pulse high, grants low, `pruning_hv`=0, `ctr`←0, `last_owner`←`owner`; → S_IDLE unconditionally.
- Non-owner request during a pass is ignored (no queueing beyond its held level); served at next S_IDLE.
- `ctr` is 0 in every state except S_PRUNE; never wraps — reaching SEQ_CYCLE_COUNT-1 always exits.
- Illegal state encoding → S_IDLE.

## Timing
- Reset (async, asserted): state=S_IDLE, `ctr`=0, `owner`=0, `last_owner`=1; all outputs 0. Reset mid-pass aborts immediately, no done pulse.
- Outputs are Moore decodes of registered state/owner/ctr; no req→gnt combinational path.
- Grant latency: request sampled high in S_IDLE at edge N → gnt, `pruning_hv`=1, `ctr`=0 in cycle N+1.
- Unstalled pass: `pruning_hv` high exactly SEQ_CYCLE_COUNT cycles, `ctr`=0..SEQ_CYCLE_COUNT-1; done in cycle N+1+SEQ_CYCLE_COUNT.
- Each stall cycle adds one cycle; segment values unrepeated with `pruning_hv`=1.
- Back-to-back: S_DONE → S_IDLE → S_PRUNE; minimum 2 idle-of-datapath cycles between passes.
- Requester must drop req no later than the cycle after its done pulse, else it re-arbitrates in S_IDLE (legal for repeated passes; round-robin still applies).

## Test plan
- Encoder only, SEQ=4, en=1: `enc_req` high at cycle 0 → `enc_gnt` cycles 1–4, `ctr`=0,1,2,3, `enc_done` pulse cycle 5, `busy` low cycle 6.
- Both requests high at cycle 0 after reset → encoder served first (done cycle 5), search granted cycle 7, `srch_done` cycle 11; third tie → encoder.
- Stall: en low cycles 2–3 during encoder pass → `ctr` holds 1, `pruning_hv`=0 those cycles, `enc_gnt` stays high, `enc_done` at cycle 7.
- Abort: `srch_req` dropped at `ctr`=2 → next cycle S_IDLE, `ctr`=0, no `srch_done`; pending `enc_req` granted next.
- Reset mid-pass at `ctr`=2 → all outputs 0 immediately; after release, tie goes to encoder.
- en low in S_IDLE with requests high → no grant, `busy`=0; en high → grant next cycle.
